// File: rtl/platform_ram_arbiter.sv
// Two-master arbiter for a shared single-port RAM; round-robin, or master-0 priority with starvation guard under PLATFORM_RAM_ARB_PRIO_EN.
// Latency: zero-cycle grant, read data returned one cycle after acceptance.
// Backpressure: a losing or idle master sees waitrequest high and must hold its request until accepted.
module platform_ram_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int BE_W     = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    logic req0, req1;
    logic grant0, grant1;
    logic pend_q, pend_d;
    logic owner_q, owner_d;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef PLATFORM_RAM_ARB_PRIO_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              force1;

    // Master 1 is forced through once it has lost MAX_WAIT cycles in a row.
    assign force1 = (wait_q == WAIT_W'(MAX_WAIT));

    always_comb begin
        grant1 = ~reset & req1 & (~req0 | force1);
        grant0 = ~reset & req0 & ~grant1;
    end

    always_comb begin
        wait_d = wait_q;
        if (grant1) begin
            wait_d = '0;
        end else if (req1) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    logic rr_last_q, rr_last_d;

    // On contention the master that did not win last time is granted.
    always_comb begin
        grant0 = ~reset & req0 & (~req1 | rr_last_q);
        grant1 = ~reset & req1 & (~req0 | ~rr_last_q);
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (grant1) begin
            rr_last_d = 1'b1;
        end else if (grant0) begin
            rr_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    assign m0_waitrequest = ~grant0;
    assign m1_waitrequest = ~grant1;
    assign ram_clken      = 1'b1;
    assign ram_chipselect = grant0 | grant1;

    always_comb begin
        ram_address    = '0;
        ram_byteenable = '0;
        ram_write      = 1'b0;
        ram_writedata  = '0;
        if (grant0) begin
            ram_address    = m0_address;
            ram_byteenable = m0_byteenable;
            ram_write      = m0_write;
            ram_writedata  = m0_writedata;
        end else if (grant1) begin
            ram_address    = m1_address;
            ram_byteenable = m1_byteenable;
            ram_write      = m1_write;
            ram_writedata  = m1_writedata;
        end
    end

    // Read+write together counts as a write, so it leaves no pending response.
    assign pend_d  = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);
    assign owner_d = grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            owner_q <= owner_d;
        end
    end

    // Gating with reset drops a response whose read was accepted just before reset rose.
    assign m0_readdatavalid = pend_q & ~owner_q & ~reset;
    assign m1_readdatavalid = pend_q & owner_q & ~reset;
    assign m0_readdata      = m0_readdatavalid ? ram_readdata : '0;
    assign m1_readdata      = m1_readdatavalid ? ram_readdata : '0;

endmodule

// File: tb/tb_platform_ram_arbiter.sv
// Directed bench for platform_ram_arbiter with a behavioural byte-enabled RAM (one-cycle read latency).
module tb_platform_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;

    logic [31:0] mem [0:4095];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    platform_ram_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .ram_address      (ram_address),
        .ram_byteenable   (ram_byteenable),
        .ram_chipselect   (ram_chipselect),
        .ram_write        (ram_write),
        .ram_writedata    (ram_writedata),
        .ram_clken        (ram_clken),
        .ram_readdata     (ram_readdata)
    );

    // Single-port RAM: byte-lane writes, registered read data.
    always @(posedge clk) begin
        if (ram_chipselect && ram_clken) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
                end
            end else begin
                ram_readdata <= mem[ram_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic rd, input logic wr, input logic [11:0] a,
                        input logic [3:0] be, input logic [31:0] d);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    endtask

    task automatic drv1(input logic rd, input logic wr, input logic [11:0] a,
                        input logic [3:0] be, input logic [31:0] d);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  prev;
        int  cnt0, cnt1;
        int  exp_cnt0, exp_cnt1;
        int  period;
        logic g1;

        for (int k = 0; k < 4096; k++) mem[k] = 32'h0;
        ram_readdata = 32'h0;
        reset = 1'b1;
        drv0(1'b1, 1'b0, 12'h000, 4'hF, 32'h0);
        drv1(1'b1, 1'b0, 12'h000, 4'hF, 32'h0);

        // Reset state, with both masters requesting.
        @(negedge clk);
        chk("rst_wait0", m0_waitrequest, 1);
        chk("rst_wait1", m1_waitrequest, 1);
        chk("rst_cs", ram_chipselect, 0);
        chk("rst_rdv0", m0_readdatavalid, 0);
        chk("rst_rdv1", m1_readdatavalid, 0);
        chk("clken", ram_clken, 1);

        next_cycle();
        reset = 1'b0;
        drv1(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        drv0(1'b0, 1'b1, 12'h005, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr5_wait0", m0_waitrequest, 0);
        chk("wr5_cs", ram_chipselect, 1);
        chk("wr5_we", ram_write, 1);
        chk("wr5_addr", ram_address, 32'h005);

        next_cycle();
        drv0(1'b1, 1'b0, 12'h005, 4'hF, 32'h0);
        @(negedge clk);
        chk("rd5_wait0", m0_waitrequest, 0);
        chk("rd5_we", ram_write, 0);

        next_cycle();
        drv0(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        @(negedge clk);
        chk("rd5_rdv0", m0_readdatavalid, 1);
        chk("rd5_data0", m0_readdata, 32'hDEADBEEF);
        chk("rd5_rdv1", m1_readdatavalid, 0);
        chk("rd5_data1", m1_readdata, 32'h0);

        // Partial byte-lane write.
        next_cycle();
        drv0(1'b0, 1'b1, 12'h010, 4'hF, 32'hFFFFFFFF);
        next_cycle();
        drv0(1'b0, 1'b1, 12'h010, 4'h1, 32'h000000AB);
        @(negedge clk);
        chk("be_wait0", m0_waitrequest, 0);
        chk("be_be", ram_byteenable, 32'h1);
        next_cycle();
        drv0(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
        next_cycle();
        drv0(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        @(negedge clk);
        chk("be_rdv0", m0_readdatavalid, 1);
        chk("be_data0", m0_readdata, 32'hFFFFFFAB);

        // Lone master 1 write, which also leaves master 1 as the last winner.
        next_cycle();
        drv1(1'b0, 1'b1, 12'h030, 4'hF, 32'h11111111);
        @(negedge clk);
        chk("m1wr_wait1", m1_waitrequest, 0);
        chk("m1wr_wait0", m0_waitrequest, 1);
        chk("m1wr_addr", ram_address, 32'h030);

        // Both masters read continuously.
`ifdef PLATFORM_RAM_ARB_PRIO_EN
        period = 5;
        exp_cnt0 = 13; exp_cnt1 = 3;
`else
        period = 2;
        exp_cnt0 = 8; exp_cnt1 = 8;
`endif
        next_cycle();
        drv0(1'b1, 1'b0, 12'h005, 4'hF, 32'h0);
        drv1(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
        prev = -1;
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin
                drv0(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
                drv1(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
            end
            @(negedge clk);
            if (i < 16) begin
                g1 = ((i % period) == (period - 1));
                chk($sformatf("contend_wait0_c%0d", i), m0_waitrequest, g1);
                chk($sformatf("contend_wait1_c%0d", i), m1_waitrequest, !g1);
            end
            if (prev < 0) begin
                chk("contend_first_rdv0", m0_readdatavalid, 0);
                chk("contend_first_rdv1", m1_readdatavalid, 0);
            end else begin
                chk($sformatf("contend_rdv0_c%0d", i), m0_readdatavalid, prev == 0);
                chk($sformatf("contend_rdv1_c%0d", i), m1_readdatavalid, prev == 1);
                chk($sformatf("contend_data0_c%0d", i), m0_readdata, (prev == 0) ? 32'hDEADBEEF : 32'h0);
                chk($sformatf("contend_data1_c%0d", i), m1_readdata, (prev == 1) ? 32'hFFFFFFAB : 32'h0);
            end
            cnt0 += int'(m0_readdatavalid);
            cnt1 += int'(m1_readdatavalid);
            if (i < 16) prev = g1 ? 1 : 0;
            next_cycle();
        end
        chk("contend_cnt0", cnt0, exp_cnt0);
        chk("contend_cnt1", cnt1, exp_cnt1);

        // Idle cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle_cs_c%0d", i), ram_chipselect, 0);
            chk($sformatf("idle_we_c%0d", i), ram_write, 0);
            chk($sformatf("idle_wait0_c%0d", i), m0_waitrequest, 1);
            chk($sformatf("idle_wait1_c%0d", i), m1_waitrequest, 1);
            chk($sformatf("idle_rdv0_c%0d", i), m0_readdatavalid, 0);
            chk($sformatf("idle_rdv1_c%0d", i), m1_readdatavalid, 0);
            chk($sformatf("idle_addr_c%0d", i), ram_address, 0);
            next_cycle();
        end

        // Read accepted, then reset asserted before its response.
        drv0(1'b1, 1'b0, 12'h020, 4'hF, 32'h0);
        @(negedge clk);
        chk("rstmid_wait0", m0_waitrequest, 0);
        next_cycle();
        reset = 1'b1;
        drv0(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        @(negedge clk);
        chk("rstmid_rdv0", m0_readdatavalid, 0);
        chk("rstmid_rdv1", m1_readdatavalid, 0);
        chk("rstmid_cs", ram_chipselect, 0);
        next_cycle();
        @(negedge clk);
        chk("rstmid_rdv0_b", m0_readdatavalid, 0);
        next_cycle();
        reset = 1'b0;
        drv0(1'b1, 1'b0, 12'h005, 4'hF, 32'h0);
        drv1(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
        @(negedge clk);
        chk("postrst_rdv0", m0_readdatavalid, 0);
        chk("postrst_wait0", m0_waitrequest, 0);
        chk("postrst_wait1", m1_waitrequest, 1);
        next_cycle();
        drv0(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        @(negedge clk);
        chk("postrst_m1_wait1", m1_waitrequest, 0);
        chk("postrst_rdv0", m0_readdatavalid, 1);
        chk("postrst_data0", m0_readdata, 32'hDEADBEEF);
        next_cycle();
        drv1(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        @(negedge clk);
        chk("postrst_rdv1", m1_readdatavalid, 1);
        chk("postrst_data1", m1_readdata, 32'hFFFFFFAB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
